fifo_stream_reader: RTL

Read-side companion to the team's asynchronous FIFO. It drains a standard-mode (non-FWFT) FIFO read port with fixed read latency. It presents the words as a valid/ready stream with full 1-word/cycle throughput and backpressure. It sits in the read clock domain between the FIFO and packet-processing logic, and it also provides a flush function that discards buffered, in-flight and FIFO-resident words.

---
 rtl/fifo_stream_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a standard-mode (non-FWFT) FIFO read port into a valid/ready stream through a skid buffer, with flush.
// Optional statistics outputs (words_delivered, words_discarded) are enabled by FIFO_STREAM_READER_STATISTICS_EN.
module fifo_stream_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    output logic                          fifo_read_enable,
    input  logic [DATA_WIDTH-1:0]         fifo_read_data,
    input  logic                          fifo_read_data_valid,
    input  logic                          fifo_empty,
    input  logic                          flush,
    output logic                          flush_busy,
    output logic [DATA_WIDTH-1:0]         stream_data,
    output logic                          stream_valid,
    input  logic                          stream_ready,
    output logic [$clog2(BUFFER_DEPTH):0] occupancy
`ifdef FIFO_STREAM_READER_STATISTICS_EN
    ,
    output logic [31:0]                   words_delivered,
    output logic [31:0]                   words_discarded
`endif
);

    localparam int PW = $clog2(BUFFER_DEPTH);
    localparam int CW = $clog2(BUFFER_DEPTH) + 1;
    localparam int IW = $clog2(READ_LATENCY + 1) + 1;

    // Handshake: a word transfers on every rising clock edge where stream_valid && stream_ready;
    // stream_data is held stable while stream_valid is high and stream_ready is low.

    typedef enum logic {
        RUNNING  = 1'b0,
        FLUSHING = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [IW-1:0]           in_flight;
    logic [DATA_WIDTH-1:0]   buffer [BUFFER_DEPTH];
    logic                    pop;
    logic                    data_accept;
    logic                    buffer_write;
    logic                    flush_entry;
    logic [CW:0]             demand;

    // Returns with nothing outstanding (e.g. reads issued before a reset) are ignored.
    assign data_accept  = fifo_read_data_valid && (in_flight != '0);
    assign stream_valid = reset_n && (state == RUNNING) && (count != '0);
    assign pop          = stream_valid && stream_ready;
    assign stream_data  = buffer[rd_ptr];
    assign occupancy    = count;

    // One bit wider than count so the subtraction of a pop can never wrap.
    assign demand = {1'b0, count} + (CW + 1)'(in_flight) - (CW + 1)'(pop);

    always_comb begin
        state_next       = state;
        fifo_read_enable = 1'b0;
        flush_busy       = 1'b0;
        flush_entry      = 1'b0;
        buffer_write     = 1'b0;
        case (state)
            RUNNING: begin
                fifo_read_enable = reset_n && !fifo_empty && (demand < (CW + 1)'(BUFFER_DEPTH));
                if (flush) begin
                    state_next  = FLUSHING;
                    flush_entry = 1'b1;
                end else begin
                    buffer_write = data_accept;
                end
            end
            FLUSHING: begin
                flush_busy       = 1'b1;
                fifo_read_enable = reset_n && !fifo_empty && (in_flight < IW'(READ_LATENCY + 1));
                if (fifo_empty && (in_flight == '0) && !flush) begin
                    state_next = RUNNING;
                end
            end
            default: state_next = RUNNING;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= RUNNING;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_flight <= '0;
        end else begin
            state <= state_next;
            case ({fifo_read_enable, data_accept})
                2'b10:   in_flight <= in_flight + IW'(1);
                2'b01:   in_flight <= in_flight - IW'(1);
                default: in_flight <= in_flight;
            endcase
            if (flush_entry) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (buffer_write) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (buffer_write && !pop) begin
                    count <= count + CW'(1);
                end else if (!buffer_write && pop) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (buffer_write) begin
            buffer[wr_ptr] <= fifo_read_data;
        end
    end

`ifdef FIFO_STREAM_READER_STATISTICS_EN
    logic [CW:0] discard_now;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // On flush entry the buffered words (minus one still popping) and any word landing that cycle are lost.
    always_comb begin
        discard_now = '0;
        if (flush_entry) begin
            discard_now = {1'b0, count} - (CW + 1)'(pop) + (CW + 1)'(data_accept);
        end else if (state == FLUSHING) begin
            discard_now = (CW + 1)'(data_accept);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            words_delivered <= '0;
            words_discarded <= '0;
        end else begin
            words_delivered <= sat_add(words_delivered, 32'(pop));
            words_discarded <= sat_add(words_discarded, 32'(discard_now));
        end
    end
`endif

endmodule
